card_dealer: RTL and testbench

- Card source for the bell game. It deals face-up cards alternately into player slot 1 and slot 2 and produces the colour/number pairs that the judge logic consumes.
- Maintains the table pile count that the scoring logic awards on a correct bell.
- Pauses dealing while a bell press is resolved. Clears the table after a correct press.
- Sits between game start control and the judge/score path; it is the producer end of the c1/c2/n1/n2/count interface.

---
 rtl/game_pkg.sv | 28 ++
 rtl/card_lfsr.sv | 33 +++
 rtl/card_dealer.sv | 156 +++++++++++++++
 tb/tb_card_dealer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared widths, encodings and card mapping for the bell game datapath.
package game_pkg;

  localparam int COLOR_W = 2;
  localparam int NUM_W   = 3;
  localparam int COUNT_W = 8;

  localparam logic [NUM_W-1:0] EMPTY_NUM = 3'd0;
  localparam logic [NUM_W-1:0] MAX_NUM   = 3'd5;

  typedef enum logic {
    SLOT1 = 1'b0,
    SLOT2 = 1'b1
  } slot_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAL = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } dealer_state_e;

  // Folds a 3-bit random field onto card numbers 1..5 (r mod 5, plus one).
  function automatic logic [NUM_W-1:0] card_num(input logic [2:0] r);
    return (r >= MAX_NUM) ? r - 3'd4 : r + 3'd1;
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with load/step; exposes the card
// that the next step will produce so the dealer can register it on the flip.
module card_lfsr
  import game_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [15:0]        seed,
  input  logic               step,
  output logic [COLOR_W-1:0] nxt_color,
  output logic [NUM_W-1:0]   nxt_num
);

  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;

  assign lfsr_nxt  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign nxt_color = lfsr_nxt[1:0];
  assign nxt_num   = card_num(lfsr_nxt[4:2]);

  always_ff @(posedge clk) begin
    if (!rst)
      lfsr <= LFSR_SEED;
    else if (load)
      lfsr <= seed;
    else if (step)
      lfsr <= lfsr_nxt;
  end

endmodule

// File: rtl/card_dealer.sv
// Card dealer for the bell game: alternate flips into two slots, pile count,
// bell lockout and table clear. Optional CARD_DEALER_RESEED_EN varies the deck per game.
module card_dealer
  import game_pkg::*;
#(
  parameter int          DEAL_PERIOD = 50_000_000,
  parameter int          LOCK_CYCLES = 25_000_000,
  parameter int          DECK_SIZE   = 56,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               bell_valid,
  input  logic               bell_right,
  output logic [COLOR_W-1:0] c1,
  output logic [NUM_W-1:0]   n1,
  output logic [COLOR_W-1:0] c2,
  output logic [NUM_W-1:0]   n2,
  output logic               card_valid,
  output logic               turn,
  output logic [COUNT_W-1:0] count,
  output logic [COUNT_W-1:0] cards_left,
  output logic               busy,
  output logic               done
);

  localparam int DT_W = $clog2(DEAL_PERIOD + 1);
  localparam int LT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [COUNT_W-1:0] DECK_CNT = COUNT_W'(DECK_SIZE);

  dealer_state_e      state;
  logic [DT_W-1:0]    deal_tmr;
  logic [LT_W-1:0]    lock_tmr;
  logic               right_q;
  logic               start_ok;
  logic               flip;
  logic [15:0]        seed;
  logic [COLOR_W-1:0] nxt_color;
  logic [NUM_W-1:0]   nxt_num;

  assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
  // A bell in the flip cycle wins, so the LFSR must not step either.
  assign flip = (state == ST_DEAL) && !bell_valid && (deal_tmr == DT_W'(DEAL_PERIOD - 1));

`ifdef CARD_DEALER_RESEED_EN
  logic [15:0] free_ctr;
  logic [15:0] mixed;

  always_ff @(posedge clk) begin
    if (!rst)
      free_ctr <= '0;
    else
      free_ctr <= free_ctr + 16'd1;
  end

  assign mixed = free_ctr ^ LFSR_SEED;
  assign seed  = (mixed == 16'd0) ? LFSR_SEED : mixed;
`else
  assign seed = LFSR_SEED;
`endif

  card_lfsr #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load      (start_ok),
    .seed      (seed),
    .step      (flip),
    .nxt_color (nxt_color),
    .nxt_num   (nxt_num)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      c1         <= '0;
      n1         <= EMPTY_NUM;
      c2         <= '0;
      n2         <= EMPTY_NUM;
      card_valid <= 1'b0;
      turn       <= SLOT1;
      count      <= '0;
      cards_left <= DECK_CNT;
      busy       <= 1'b0;
      done       <= 1'b0;
      deal_tmr   <= '0;
      lock_tmr   <= '0;
      right_q    <= 1'b0;
    end else begin
      card_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_DEAL;
            busy       <= 1'b1;
            done       <= 1'b0;
            cards_left <= DECK_CNT;
            count      <= '0;
            c1         <= '0;
            n1         <= EMPTY_NUM;
            c2         <= '0;
            n2         <= EMPTY_NUM;
            turn       <= SLOT1;
            deal_tmr   <= '0;
          end
        end
        ST_DEAL: begin
          if (bell_valid) begin
            state    <= ST_HOLD;
            lock_tmr <= '0;
            right_q  <= bell_right;
          end else if (flip) begin
            deal_tmr   <= '0;
            card_valid <= 1'b1;
            turn       <= ~turn;
            if (slot_e'(turn) == SLOT1) begin
              c1 <= nxt_color;
              n1 <= nxt_num;
            end else begin
              c2 <= nxt_color;
              n2 <= nxt_num;
            end
            if (count != {COUNT_W{1'b1}})
              count <= count + COUNT_W'(1);
            cards_left <= cards_left - COUNT_W'(1);
            if (cards_left == COUNT_W'(1)) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            deal_tmr <= deal_tmr + DT_W'(1);
          end
        end
        ST_HOLD: begin
          if (lock_tmr == LT_W'(LOCK_CYCLES - 1)) begin
            state    <= ST_DEAL;
            deal_tmr <= '0;
            // A correct bell awards the pile, so the table starts empty again.
            if (right_q) begin
              count <= '0;
              c1    <= '0;
              n1    <= EMPTY_NUM;
              c2    <= '0;
              n2    <= EMPTY_NUM;
            end
          end else begin
            lock_tmr <= lock_tmr + LT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: stimulus pushes expected table snapshots,
// a negedge monitor pops and compares them on every card_valid.
module tb_card_dealer;

  localparam int DP = 4;
  localparam int LC = 3;
  localparam int DS = 6;

  logic       clk;
  logic       rst;
  logic       start;
  logic       bell_valid;
  logic       bell_right;
  logic [1:0] c1;
  logic [2:0] n1;
  logic [1:0] c2;
  logic [2:0] n2;
  logic       card_valid;
  logic       turn;
  logic [7:0] count;
  logic [7:0] cards_left;
  logic       busy;
  logic       done;

  card_dealer #(
    .DEAL_PERIOD (DP),
    .LOCK_CYCLES (LC),
    .DECK_SIZE   (DS),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bell_valid (bell_valid),
    .bell_right (bell_right),
    .c1         (c1),
    .n1         (n1),
    .c2         (c2),
    .n2         (n2),
    .card_valid (card_valid),
    .turn       (turn),
    .count      (count),
    .cards_left (cards_left),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] c1;
    logic [2:0] n1;
    logic [1:0] c2;
    logic [2:0] n2;
    logic       turn;
    logic [7:0] count;
    logic [7:0] left;
  } exp_t;

  exp_t q[$];

  logic [15:0] m_lfsr;
  logic [1:0]  m_c1, m_c2;
  logic [2:0]  m_n1, m_n2;
  logic        m_turn;
  logic [7:0]  m_count, m_left;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] golden_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic model_start();
    m_lfsr  = 16'hACE1;
    m_c1    = '0; m_n1 = '0; m_c2 = '0; m_n2 = '0;
    m_turn  = 1'b0;
    m_count = '0;
    m_left  = 8'(DS);
  endtask

  task automatic model_clear();
    m_c1 = '0; m_n1 = '0; m_c2 = '0; m_n2 = '0;
    m_count = '0;
  endtask

  task automatic push_card();
    exp_t e;
    int   ni;
    m_lfsr = golden_step(m_lfsr);
    ni = int'(m_lfsr[4:2]) % 5 + 1;
    if (m_turn == 1'b0) begin
      m_c1 = m_lfsr[1:0]; m_n1 = 3'(ni);
    end else begin
      m_c2 = m_lfsr[1:0]; m_n2 = 3'(ni);
    end
    m_turn = ~m_turn;
    if (m_count != 8'hFF) m_count = m_count + 8'd1;
    m_left = m_left - 8'd1;
    e.c1 = m_c1; e.n1 = m_n1; e.c2 = m_c2; e.n2 = m_n2;
    e.turn = m_turn; e.count = m_count; e.left = m_left;
    q.push_back(e);
  endtask

  // Monitor: every flip must match the next queued expectation.
  always @(negedge clk) begin
    if (card_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_card: card_valid with empty queue at cycle %0d", cyc);
      end else begin
        exp_t e;
        logic [2:0] nn;
        e = q.pop_front();
        chk("slots", {c1, n1, c2, n2}, {e.c1, e.n1, e.c2, e.n2});
        chk("turn", turn, e.turn);
        chk("count", count, e.count);
        chk("cards_left", cards_left, e.left);
        nn = turn ? n1 : n2;
        chk("n_range", (nn >= 3'd1 && nn <= 3'd5), 1);
      end
    end
  end

  task automatic at_cycle(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_start(output int ts);
    @(posedge clk); #1;
    start = 1'b1;
    ts = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic bell_at(input int b, input logic r);
    while (cyc < b - 1) begin
      @(posedge clk); #1;
    end
    bell_valid = 1'b1;
    bell_right = r;
    @(posedge clk); #1;
    bell_valid = 1'b0;
    bell_right = 1'b0;
  endtask

  task automatic expect_flip(input string name, input int exp_at, output int seen_at);
    int waited = 0;
    seen_at = -1;
    do begin
      @(negedge clk);
      waited++;
    end while (!card_valid && waited < 60);
    if (!card_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: no card_valid within 60 cycles, expected at cycle %0d", name, exp_at);
    end else begin
      seen_at = cyc;
      chk(name, seen_at, exp_at);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_slots"}, {c1, n1, c2, n2}, 10'd0);
    chk({tag, "_card_valid"}, card_valid, 0);
    chk({tag, "_turn"}, turn, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_cards_left"}, cards_left, DS);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int ts, f, b, nv;
    rst = 1'b0; start = 1'b0; bell_valid = 1'b0; bell_right = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Game 1: full deck, fixed period, hand-computed first three cards.
    model_start();
    pulse_start(ts);
    push_card(); expect_flip("flip1_time", ts + DP, f);
    chk("card1_hand", {c1, n1}, {2'd3, 3'd1});
    push_card(); expect_flip("flip2_time", ts + 2*DP, f);
    chk("card2_hand", {c2, n2}, {2'd3, 3'd2});
    push_card(); expect_flip("flip3_time", ts + 3*DP, f);
    chk("card3_hand", {c1, n1}, {2'd3, 3'd4});
    for (int i = 4; i <= DS; i++) begin
      push_card();
      expect_flip("flip_time", ts + i*DP, f);
    end
    chk("g1_done", done, 1);
    chk("g1_busy", busy, 0);
    chk("g1_left", cards_left, 0);
    chk("g1_count", count, 6);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (card_valid) nv++;
    end
    chk("g1_quiet", nv, 0);
    chk("g1_done_hold", done, 1);

    // Game 2: right bell at count 3, then wrong bell on a flip cycle.
    model_start();
    pulse_start(ts);
    push_card(); expect_flip("g2_flip1", ts + DP, f);
    push_card(); expect_flip("g2_flip2", ts + 2*DP, f);
    push_card(); expect_flip("g2_flip3", ts + 3*DP, f);
    b = f + 2;
    bell_at(b, 1'b1);
    for (int k = 0; k < LC; k++) begin
      at_cycle(b + k);
      chk("hold_count", count, 3);
      chk("hold_busy", busy, 1);
      chk("hold_novalid", card_valid, 0);
    end
    at_cycle(b + LC);
    chk("clear_count", count, 0);
    chk("clear_slots", {c1, n1, c2, n2}, 10'd0);
    chk("clear_turn", turn, 1);
    model_clear();
    push_card(); expect_flip("g2_flip4", b + LC + DP, f);
    b = f + DP;
    bell_at(b, 1'b0);
    at_cycle(b);
    chk("wrong_noflip", card_valid, 0);
    at_cycle(b + LC);
    chk("wrong_count", count, 1);
    chk("wrong_busy", busy, 1);
    push_card(); expect_flip("g2_flip5", b + LC + DP, f);
    push_card(); expect_flip("g2_flip6", f + DP, f);
    chk("g2_done", done, 1);
    chk("g2_count", count, 3);
    chk("g2_left", cards_left, 0);

    // Game 3: reset during HOLD, then replay from a fresh start.
    model_start();
    pulse_start(ts);
    push_card(); expect_flip("g3_flip1", ts + DP, f);
    push_card(); expect_flip("g3_flip2", ts + 2*DP, f);
    bell_at(f + 1, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset("midreset");
    chk("midreset_queue", q.size(), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    model_start();
    pulse_start(ts);
    for (int i = 1; i <= DS; i++) begin
      push_card();
      expect_flip("replay_time", ts + i*DP, f);
    end
    chk("replay_done", done, 1);
    chk("replay_count", count, 6);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
